// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame decoder.
package spi_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;
  localparam logic [7:0] CMD_WRITE      = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    LEN,
    DATA,
    CHK,
    COMMIT,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_ABORT = 2'b00,
    ERR_CMD   = 2'b01,
    ERR_LEN   = 2'b10,
    ERR_CHK   = 2'b11
  } err_t;

endpackage

// File: rtl/spi_frame_buf.sv
// Payload buffer: single-port byte array, synchronous write, combinational read.
module spi_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [7:0] mem [DEPTH];

  // Store a payload byte at the current index.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/spi_frame_decoder.sv
// Assembles SYNC/CMD/ADDR/LEN/payload/CHK frames from the SPI byte stream,
// validates them and replays the payload as one register write per cycle.
module spi_frame_decoder
  import spi_frame_pkg::*;
#(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       cs,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       rx_drop,
  output logic       busy
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic       cs_meta_q, cs_meta_d;
  logic       cs_sync_q, cs_sync_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  err_t       err_code_q, err_code_d;

  logic             buf_we;
  logic [IDX_W-1:0] buf_addr;
  logic [7:0]       buf_rdata;
  logic             rx_state;

  spi_frame_buf #(.DEPTH(MAX_LEN), .AW(IDX_W)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (buf_addr),
    .wdata (rx_data),
    .rdata (buf_rdata)
  );

  assign rx_state = (state_q == CMD) || (state_q == ADDR) || (state_q == LEN) ||
                    (state_q == DATA) || (state_q == CHK);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    cs_meta_d    = cs;
    cs_sync_d    = cs_meta_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    buf_we       = 1'b0;
    buf_addr     = idx_q[IDX_W-1:0];
    rx_drop      = 1'b0;

    if (rx_state && cs_sync_q) begin
      // Deselect mid-frame wins over any byte arriving in the same cycle.
      state_d     = ERR;
      frame_err_d = 1'b1;
      err_code_d  = ERR_ABORT;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) state_d = CMD;
        end
        CMD: begin
          if (rx_valid) begin
            chk_d = rx_data;
            if (rx_data != CMD_WRITE) begin
              state_d     = ERR;
              frame_err_d = 1'b1;
              err_code_d  = ERR_CMD;
            end else begin
              state_d = ADDR;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr_d  = rx_data;
            chk_d   = chk_q ^ rx_data;
            state_d = LEN;
          end
        end
        LEN: begin
          if (rx_valid) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              state_d     = ERR;
              frame_err_d = 1'b1;
              err_code_d  = ERR_LEN;
            end else begin
              len_d   = rx_data;
              idx_d   = 8'd0;
              chk_d   = chk_q ^ rx_data;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            buf_we = 1'b1;
            chk_d  = chk_q ^ rx_data;
            idx_d  = idx_q + 8'd1;
            if (idx_q == 8'(len_q - 8'd1)) state_d = CHK;
          end
        end
        CHK: begin
          // Read slot 0 now so the first write leaves the cycle after CHK.
          buf_addr = '0;
          if (rx_valid) begin
            if (rx_data != chk_q) begin
              state_d     = ERR;
              frame_err_d = 1'b1;
              err_code_d  = ERR_CHK;
            end else begin
              state_d   = COMMIT;
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = buf_rdata;
              idx_d     = 8'd1;
            end
          end
        end
        COMMIT: begin
          // idx_q runs one ahead of the write currently on the outputs.
          rx_drop = rx_valid;
          if (idx_q == len_q) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q + idx_q;
            wr_data_d = buf_rdata;
            idx_d     = idx_q + 8'd1;
          end
        end
        ERR: begin
          rx_drop = rx_valid;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; cs sync idles deselected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= 8'd0;
      len_q        <= 8'd0;
      idx_q        <= 8'd0;
      chk_q        <= 8'd0;
      cs_meta_q    <= 1'b1;
      cs_sync_q    <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 8'd0;
      wr_data_q    <= 8'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_ABORT;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      cs_meta_q    <= cs_meta_d;
      cs_sync_q    <= cs_sync_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder.
module tb_spi_frame_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cs;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_drop;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wlog[$];
  int          n_done = 0;
  int          n_err  = 0;
  logic [7:0]  fr[$];

  spi_frame_decoder #(.MAX_LEN(16), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cs         (cs),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .rx_drop    (rx_drop),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Log every write and count pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) wlog.push_back({wr_addr, wr_data});
    if (frame_done) n_done++;
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_fr();
    foreach (fr[i]) send(fr[i]);
  endtask

  int w0, e0, d0;

  initial begin
    rst = 1'b0; cs = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done_err_drop", {frame_done, frame_err, rx_drop}, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (4) step();

    // Good two-byte frame.
    e0 = n_err; d0 = n_done;
    fr = {8'hA5, 8'h01, 8'h10, 8'h02, 8'h55, 8'hAA, 8'hEC};
    send_fr();
    chk("good_w0", {wr_en, wr_addr, wr_data}, {1'b1, 8'h10, 8'h55});
    chk("good_busy", busy, 1);
    step();
    chk("good_w1", {wr_en, wr_addr, wr_data}, {1'b1, 8'h11, 8'hAA});
    step();
    chk("good_done", {wr_en, frame_done}, 2'b01);
    chk("good_hold", {wr_addr, wr_data}, 16'h11AA);
    step();
    chk("good_done_pulse", {frame_done, busy}, 2'b00);
    chk("good_no_err", n_err - e0, 0);
    chk("good_done_cnt", n_done - d0, 1);

    // Bad checksum.
    w0 = wlog.size();
    fr = {8'hA5, 8'h01, 8'h10, 8'h02, 8'h55, 8'hAA, 8'hED};
    send_fr();
    chk("chk_err", {frame_err, err_code, wr_en}, {1'b1, 2'b11, 1'b0});
    step();
    chk("chk_after", {frame_err, busy}, 2'b00);
    chk("chk_nowr", wlog.size() - w0, 0);

    // Bad command: error right after the CMD byte.
    fr = {8'hA5, 8'h02};
    send_fr();
    chk("cmd_err", {frame_err, err_code}, {1'b1, 2'b01});
    step();
    chk("cmd_pulse", frame_err, 0);

    // Zero length.
    fr = {8'hA5, 8'h01, 8'h10, 8'h00};
    send_fr();
    chk("len0_err", {frame_err, err_code}, {1'b1, 2'b10});
    step();

    // Length above MAX_LEN.
    fr = {8'hA5, 8'h01, 8'h10, 8'h11};
    send_fr();
    chk("len17_err", {frame_err, err_code}, {1'b1, 2'b10});
    step();
    chk("len_nowr", wlog.size() - w0, 0);

    // Abort by chip-select mid-payload.
    fr = {8'hA5, 8'h01, 8'h10, 8'h02, 8'h55};
    send_fr();
    cs = 1'b1;
    for (int i = 0; i < 8 && !frame_err; i++) step();
    chk("abort_err", {frame_err, err_code}, {1'b1, 2'b00});
    cs = 1'b0;
    repeat (4) step();
    chk("abort_nowr", wlog.size() - w0, 0);
    chk("abort_idle", busy, 0);

    // Address wrap 0xFF -> 0x00.
    fr = {8'hA5, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCF};
    send_fr();
    repeat (3) step();
    chk("wrap_cnt", wlog.size() - w0, 2);
    if (wlog.size() - w0 == 2) begin
      chk("wrap_w0", wlog[w0], 16'hFF11);
      chk("wrap_w1", wlog[w0 + 1], 16'h0022);
    end

    // Leading garbage, then a one-byte frame with a byte during COMMIT.
    w0 = wlog.size(); d0 = n_done;
    fr = {8'h00, 8'h13, 8'hA5, 8'h01, 8'h20, 8'h01, 8'h7E, 8'h5E};
    send_fr();
    rx_data = 8'hA5; rx_valid = 1'b1;
    #1;
    chk("drop_pulse", rx_drop, 1);
    chk("drop_w0", {wr_en, wr_addr, wr_data}, {1'b1, 8'h20, 8'h7E});
    step();
    rx_valid = 1'b0;
    chk("drop_done", {frame_done, rx_drop, wr_en}, 3'b100);
    step();
    chk("drop_cnt", wlog.size() - w0, 1);
    chk("drop_idle", busy, 0);

    // Async reset in the middle of a payload.
    fr = {8'hA5, 8'h01, 8'h10, 8'h02, 8'h55};
    send_fr();
    #5 rst = 1'b0;
    #1;
    chk("mrst_outs", {wr_en, wr_addr, wr_data, frame_done, frame_err, err_code, busy}, 0);
    step();
    rst = 1'b1;
    repeat (4) step();
    w0 = wlog.size(); d0 = n_done;
    fr = {8'hA5, 8'h01, 8'h10, 8'h02, 8'h55, 8'hAA, 8'hEC};
    send_fr();
    repeat (3) step();
    chk("mrst_cnt", wlog.size() - w0, 2);
    if (wlog.size() - w0 == 2) begin
      chk("mrst_w0", wlog[w0], 16'h1055);
      chk("mrst_w1", wlog[w0 + 1], 16'h11AA);
    end
    chk("mrst_done", n_done - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
